// File: rtl/recarbitbank.sv
// Receive arbitration/ID register bank: CPU and LLC write ports with runtime collision
// priority and a one-deep pending buffer that replays the losing write on an idle cycle.
module recarbitbank #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu,
    input  logic [AW-1:0]         i_cpu_addr,
    input  logic [WIDTH-1:0]      i_reginp,
    input  logic                  i_can,
    input  logic [AW-1:0]         i_can_addr,
    input  logic [WIDTH-1:0]      i_recidin,
    input  logic                  i_prio_can,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data_c,
    output logic [NREG*WIDTH-1:0] o_regout,
    output logic [NREG-1:0]       o_upd,
    output logic                  o_pend,
    output logic                  o_ovf,
    input  logic                  i_ovf_clr
);

    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_upd;
    logic             r_pend;
    logic [AW-1:0]    r_pend_addr;
    logic [WIDTH-1:0] r_pend_data;
    logic             r_ovf;

    logic             w_cpu_v;
    logic             w_can_v;
    logic             w_coll;
    logic             w_cpu_wr;
    logic             w_can_wr;
    logic             w_drain;
    logic             w_hit;
    logic [NREG-1:0]  w_wen;
    logic [WIDTH-1:0] w_wdat [NREG];
    logic [AW-1:0]    w_lose_addr;
    logic [WIDTH-1:0] w_lose_data;

    // Request qualification and collision resolution
    always_comb begin
        w_cpu_v     = i_cpu && (32'(i_cpu_addr) < NREG);
        w_can_v     = i_can && (32'(i_can_addr) < NREG);
        w_coll      = w_cpu_v && w_can_v && (i_cpu_addr == i_can_addr);
        w_cpu_wr    = w_cpu_v && (!w_coll || !i_prio_can);
        w_can_wr    = w_can_v && (!w_coll || i_prio_can);
        w_drain     = r_pend && !i_cpu && !i_can;
        w_hit       = r_pend && ((w_cpu_wr && (i_cpu_addr == r_pend_addr)) ||
                                 (w_can_wr && (i_can_addr == r_pend_addr)));
        w_lose_addr = i_prio_can ? i_cpu_addr : i_can_addr;
        w_lose_data = i_prio_can ? i_reginp : i_recidin;
    end

    // Per-entry write enable and data select; drain never coincides with a live request
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            w_wen[i]  = 1'b0;
            w_wdat[i] = '0;
            if (w_cpu_wr && (i_cpu_addr == AW'(i))) begin
                w_wen[i]  = 1'b1;
                w_wdat[i] = i_reginp;
            end else if (w_can_wr && (i_can_addr == AW'(i))) begin
                w_wen[i]  = 1'b1;
                w_wdat[i] = i_recidin;
            end else if (w_drain && (r_pend_addr == AW'(i))) begin
                w_wen[i]  = 1'b1;
                w_wdat[i] = r_pend_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
            r_upd       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_ovf       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (w_wen[i]) r_regs[i] <= w_wdat[i];
            end
            r_upd <= w_wen;
            // A new loser always takes the buffer; otherwise drain or supersede empties it
            if (w_coll) begin
                r_pend      <= 1'b1;
                r_pend_addr <= w_lose_addr;
                r_pend_data <= w_lose_data;
            end else if (w_drain || w_hit) begin
                r_pend      <= 1'b0;
            end
            if (w_coll && r_pend) r_ovf <= 1'b1;
            else if (i_ovf_clr)   r_ovf <= 1'b0;
        end
    end

    always_comb begin
        o_rd_data_c = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (i_rd_addr == AW'(i)) o_rd_data_c = r_regs[i];
        end
    end

    for (genvar g = 0; g < int'(NREG); g++) begin : g_out
        assign o_regout[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign o_upd  = r_upd;
    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule
